dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: number of consecutive cycles a pending debug request may be denied before it is forced a slot; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 p_req  input  1  pipeline MEM-stage access request, this cycle.
REQ-005 p_we  input  1  pipeline access is a write.
REQ-006 p_addr, p_wdata  input  16 each  pipeline address / store data.
REQ-007 p_rdata  output  16  pipeline load data, valid one cycle after the granted read.
REQ-008 p_stall  output  1  pipeline access denied this cycle; pipeline holds the MEM stage.
REQ-009 d_req  input  1  debug/loader request; held with d_we, d_addr, d_wdata stable until d_ack.
REQ-010 d_we  input  1; d_addr, d_wdata  input  16 each  debug access fields.
REQ-011 d_ack  output  1  one-cycle completion pulse; d_rdata  output  16  valid while d_ack=1.
REQ-012 mem_addr, mem_wdata  output  16 each; mem_write  output  1  to data memory.
REQ-013 mem_rdata  input  16  data memory read data, synchronous read: valid the cycle after the address is presented.

Function
REQ-014 FSM states: IDLE, DGRANT (debug owns memory this cycle), DRESP (debug ack cycle); state is registered.
REQ-015 IDLE or DRESP: memory muxed to pipeline; mem_addr=p_addr, mem_wdata=p_wdata, mem_write=p_req&p_we; p_stall=0.
REQ-016 DGRANT: memory muxed to debug; mem_addr=d_addr, mem_wdata=d_wdata, mem_write=d_we; p_stall=p_req.
REQ-017 Transition IDLE->DGRANT when d_req=1 and (p_req=0 or starve_cnt==STARVE_MAX); otherwise stay IDLE.
REQ-018 DGRANT->DRESP unconditionally; DRESP->IDLE unconditionally (no back-to-back debug grant; requester drops d_req during its ack cycle).
REQ-019 d_ack=1 exactly when state==DRESP; d_rdata=mem_rdata in that cycle; d_rdata value when d_ack=0 is don't-care.
REQ-020 p_rdata=mem_rdata at all times (combinational pass-through); pipeline samples it the cycle after its granted read.
REQ-021 starve_cnt (4 bits): in IDLE with d_req=1 and p_req=1 and no grant, increments, saturating at STARVE_MAX; cleared on entry to DGRANT; held otherwise.
REQ-022 At most one mem_write per cycle; pipeline write and debug write are never issued in the same cycle.
REQ-023 Pipeline request in DGRANT is stalled, not dropped: pipeline re-presents it in DRESP, where it is served.
REQ-024 Debug request arriving in DGRANT/DRESP is first considered in IDLE.
REQ-025 Maximum debug latency from d_req rise to d_ack: STARVE_MAX+2 cycles under continuous pipeline traffic; 2 cycles with pipeline idle.

Reset
REQ-026 rst=0 asynchronously forces state=IDLE, starve_cnt=0, d_ack=0, p_stall=0, and mem_write=0 while rst=0.
REQ-027 Reset during DGRANT aborts the debug access: no write is committed and no d_ack is issued; requester must re-request after reset.
REQ-028 First grant decision occurs on the first rising clk edge after rst returns high.

Verification
REQ-029 Pipeline only: p_req=1, p_we=1, p_addr=0x0010, p_wdata=0xBEEF, then read 0x0010 -> mem_write=1 one cycle, p_stall never 1, p_rdata=0xBEEF the cycle after the read.
REQ-030 Debug only: d_req=1, d_we=0, d_addr=0x0020 (memory holds 0x1234) -> DGRANT next cycle, d_ack=1 with d_rdata=0x1234 two cycles after request, single pulse.
REQ-031 Starvation: p_req held 1, d_req=1 write 0x0030<-0x5A5A, STARVE_MAX=4 -> p_stall=1 in exactly one cycle, after 4 denied cycles; d_ack 6 cycles after request; memory[0x0030]=0x5A5A.
REQ-032 Collision: d_req and p_req rise in the same cycle with starve_cnt=0 -> pipeline served, starve_cnt=1; with p_req=0 on next cycle -> debug granted.
REQ-033 Reset in DGRANT with d_we=1, d_addr=0x0040 -> mem_write=0 immediately, memory[0x0040] unchanged, no d_ack, state=IDLE, starve_cnt=0.
REQ-034 Back-to-back: d_req held through d_ack -> no second DGRANT in the cycle after DRESP unless d_req remains asserted in IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a debug/loader port.
// The pipeline normally owns memory. A debug request is granted a one-cycle slot when the pipeline is idle, or after bounded starvation.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [15:0] p_addr,
    input  logic [15:0] p_wdata,
    output logic [15:0] p_rdata,
    output logic        p_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    input  logic [15:0] mem_rdata
);

    // state  | meaning
    // IDLE   | pipeline owns memory, debug requests are arbitrated here
    // DGRANT | debug owns memory this cycle, pipeline stalled
    // DRESP  | debug ack cycle, pipeline owns memory again
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        DRESP  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       dbg_own;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    if (!p_req || starve_cnt_q == STARVE_LIM) begin
                        state_d      = DGRANT;
                        starve_cnt_d = 4'd0;
                    end else begin
                        // reaching here implies the count is still below the limit
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            DGRANT:  state_d = DRESP;
            DRESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dbg_own   = (state_q == DGRANT);
        mem_addr  = dbg_own ? d_addr  : p_addr;
        mem_wdata = dbg_own ? d_wdata : p_wdata;
        // gate with reset so no write can leak out while reset is low
        mem_write = rst & (dbg_own ? d_we : (p_req & p_we));
        p_stall   = dbg_own & p_req;
        d_ack     = (state_q == DRESP);
        d_rdata   = mem_rdata;
        p_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural ownership/memory model.
module tb_dmem_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, p_stall, d_req, d_we, d_ack, mem_write;
    logic [15:0] p_addr, p_wdata, p_rdata, d_addr, d_wdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    // data memory with synchronous read (old data on read-during-write)
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: ph 0 = pipeline owns, 1 = debug slot, 2 = debug ack cycle
    bit          model_on = 0;
    int          ph = 0, denied = 0, lat = 0;
    bit          pr_v = 0, trk = 0, dbg;
    logic [15:0] pr_val, dr_val, e_addr, e_wd;
    logic        e_we;

    always @(negedge clk) begin
        if (!rst) begin
            ph = 0; denied = 0; pr_v = 0; trk = 0; lat = 0;
        end else if (model_on) begin
            dbg    = (ph == 1);
            e_we   = dbg ? d_we : (p_req & p_we);
            e_addr = dbg ? d_addr : p_addr;
            e_wd   = dbg ? d_wdata : p_wdata;
            chk("mem_write", mem_write, e_we);
            if (dbg || p_req) chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wd);
            chk("p_stall", p_stall, dbg & p_req);
            chk("d_ack", d_ack, ph == 2);
            if (ph == 2) chk("d_rdata", d_rdata, dr_val);
            if (pr_v) chk("p_rdata", p_rdata, pr_val);
            if (ph == 2) begin
                chk("dbg_latency_bound", lat <= SM + 2, 1'b1);
                trk = 0;
            end else if (d_req && !trk) begin
                trk = 1; lat = 0;
            end
            if (trk) lat++;
            pr_v = !dbg && p_req && !p_we;
            if (pr_v) pr_val = ref_mem[p_addr[7:0]];
            if (dbg) dr_val = ref_mem[d_addr[7:0]];
            if (e_we) ref_mem[e_addr[7:0]] = e_wd;
            case (ph)
                1: ph = 2;
                2: ph = 0;
                default: begin
                    if (d_req && (!p_req || denied == SM)) begin
                        ph = 1; denied = 0;
                    end else if (d_req) begin
                        denied = (denied < SM) ? denied + 1 : SM;
                    end
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int stalls, stall_at, ack_at, dens;
    bit hold_p;

    initial begin
        rst = 1'b0;
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'hA000 | 16'(i);
            ref_mem[i] = 16'hA000 | 16'(i);
        end

        // reset holds everything quiet even with a pipeline write pending
        @(posedge clk); #1;
        p_req = 1; p_we = 1; #1;
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_p_stall", p_stall, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_starve", dut.starve_cnt_q, 4'd0);
        p_req = 0; p_we = 0;
        @(posedge clk); #3;
        rst = 1'b1; model_on = 1;

        // pipeline write then read back
        cyc(); p_req = 1; p_we = 1; p_addr = 16'h0010; p_wdata = 16'hBEEF; #2;
        chk("pipe_wr_mem_write", mem_write, 1'b1);
        chk("pipe_wr_stall", p_stall, 1'b0);
        cyc(); p_we = 0; #2;
        chk("pipe_rd_mem_write", mem_write, 1'b0);
        cyc(); p_req = 0; #2;
        chk("pipe_rd_data", p_rdata, 16'hBEEF);

        // debug read with idle pipeline
        cyc(); p_req = 1; p_we = 1; p_addr = 16'h0020; p_wdata = 16'h1234;
        cyc(); p_req = 0; p_we = 0; d_req = 1; d_we = 0; d_addr = 16'h0020; #2;
        chk("dbg_rd_c0_ack", d_ack, 1'b0);
        cyc(); #2;
        chk("dbg_rd_grant_addr", mem_addr, 16'h0020);
        chk("dbg_rd_c1_ack", d_ack, 1'b0);
        cyc(); d_req = 0; #2;
        chk("dbg_rd_ack", d_ack, 1'b1);
        chk("dbg_rd_data", d_rdata, 16'h1234);
        cyc(); #2;
        chk("dbg_rd_single_pulse", d_ack, 1'b0);

        // starvation under continuous pipeline reads
        cyc(); d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h5A5A;
        p_req = 1; p_we = 0; p_addr = 16'h0001;
        stalls = 0; stall_at = -1; ack_at = -1;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) d_req = 0;
            #2;
            if (p_stall) begin
                stalls++;
                if (stall_at < 0) stall_at = k;
            end
            if (d_ack && ack_at < 0) ack_at = k;
            cyc();
        end
        chk("starve_stall_count", stalls, 1);
        chk("starve_stall_cycle", stall_at, 5);
        chk("starve_ack_cycle", ack_at, 6);
        p_addr = 16'h0030;
        cyc(); p_req = 0; #2;
        chk("starve_mem_written", p_rdata, 16'h5A5A);

        // collision: pipeline wins first, debug granted once pipeline goes quiet
        cyc(); d_req = 1; d_we = 0; d_addr = 16'h0003; p_req = 1; p_we = 0; p_addr = 16'h0005; #2;
        chk("coll_p_stall", p_stall, 1'b0);
        chk("coll_mem_addr", mem_addr, 16'h0005);
        cyc(); p_req = 0; #2;
        chk("coll_starve", dut.starve_cnt_q, 4'd1);
        chk("coll_idle_ack", d_ack, 1'b0);
        cyc(); #2;
        chk("coll_dbg_grant", mem_addr, 16'h0003);
        cyc(); d_req = 0; #2;
        chk("coll_ack", d_ack, 1'b1);

        // reset during a debug write slot aborts it
        cyc(); d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'hDEAD;
        cyc(); #2;
        chk("rstdg_write_before", mem_write, 1'b1);
        rst = 1'b0; #1;
        chk("rstdg_mem_write", mem_write, 1'b0);
        chk("rstdg_starve", dut.starve_cnt_q, 4'd0);
        chk("rstdg_ack", d_ack, 1'b0);
        d_req = 0; d_we = 0;
        @(posedge clk); #3;
        rst = 1'b1;
        cyc(); p_req = 1; p_we = 0; p_addr = 16'h0040; #2;
        chk("rstdg_no_ack", d_ack, 1'b0);
        cyc(); p_req = 0; #2;
        chk("rstdg_mem_kept", p_rdata, 16'hA040);

        // debug request held through ack gets a fresh grant only via IDLE
        cyc(); d_req = 1; d_we = 0; d_addr = 16'h0010;
        cyc();
        cyc(); #2;
        chk("b2b_ack1", d_ack, 1'b1);
        cyc(); p_addr = 16'h0002; #2;
        chk("b2b_idle_ack", d_ack, 1'b0);
        chk("b2b_idle_owner", mem_addr, 16'h0002);
        cyc(); p_req = 1; p_we = 0; #2;
        chk("b2b_regrant_stall", p_stall, 1'b1);
        chk("b2b_regrant_addr", mem_addr, 16'h0010);
        cyc(); d_req = 0; #2;
        chk("b2b_ack2", d_ack, 1'b1);
        chk("b2b_resp_stall", p_stall, 1'b0);
        cyc(); p_req = 0;
        cyc();

        // randomized traffic with varying pipeline density
        hold_p = 0;
        for (int n = 0; n < 3000; n++) begin
            dens = (n < 1000) ? 50 : ((n < 2000) ? 100 : 20);
            if (ph == 2) d_req = 0;
            else if (!d_req && ph == 0 && $urandom_range(0, 3) == 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 31));
                d_wdata = 16'($urandom);
            end
            if (!hold_p) begin
                p_req   = ($urandom_range(0, 99) < dens);
                p_we    = 1'($urandom_range(0, 1));
                p_addr  = 16'($urandom_range(0, 31));
                p_wdata = 16'($urandom);
            end
            hold_p = (ph == 1) && p_req;
            cyc();
        end
        p_req = 0;
        if (ph == 2) d_req = 0;
        cyc();
        d_req = 0;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
